input_shift_register: RTL
=========================

Name: input_shift_register

Overview:
- Input Shift Register (ISR) for one PIO state-machine core; the receive-side counterpart of the output shift register.
- Sits between GPIO sampling (gpio in_data) and the RX fifo: it shifts sampled pin bits in, then pushes completed words into the fifo's data_in/push_en.
- Supports explicit push, autopush at a programmable threshold, and a stall when the RX fifo is full.

Parameters:
- WIDTH, 32, shift register and data width; must be a power of two ≥ 8.
- CNT_W, $clog2(WIDTH)+1, width of the shift counter; derived, do not override.

Ports:
- clk  input  1  core clock
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- in_data  input  WIDTH  sampled pin data; the LSBs are the source bits
- shift_en  input  1  perform an IN shift this cycle
- shift_count  input  5  bits to shift; 0 means WIDTH
- shiftdir  input  1  1 = shift right (new bits enter at the MSB end); 0 = shift left (new bits enter at bit 0)
- autopush  input  1  enable autopush
- push_thresh  input  5  autopush threshold; 0 means WIDTH
- push_req  input  1  explicit PUSH instruction
- mov  input  2  00 none, 01 write ISR, 10 read, 11 read-and-clear
- mov_in  input  WIDTH  MOV source data
- mov_out  output  WIDTH  registered MOV read result
- status  input  fifo_status  RX fifo status; only .full is used
- fifo_data  output  WIDTH  word to push; connects to fifo data_in
- fifo_push_en  output  1  one-cycle push strobe; connects to fifo push_en
- isr  output  WIDTH  current ISR contents
- input_shift_counter  output  CNT_W  bits accumulated, saturating at WIDTH
- stall  output  1  core must hold PC and re-present the instruction

Behaviour:
- Reset (rst==0, asynchronous):
  - isr, fifo_data, mov_out = 0; input_shift_counter = 0; fifo_push_en = 0; stall = 0.
  - State = IDLE. Releasing reset mid-operation discards any pending push.
- States: IDLE and PUSH_PENDING.
- fifo_push_en is registered. It is high for exactly one cycle, in the cycle after the push decision; fifo_data is valid in the same cycle.
- Shift (IDLE, shift_en=1), with n = shift_count==0 ? WIDTH : shift_count:
  - Right shift: isr_next = (isr >> n) | (in_data[n-1:0] << (WIDTH-n)).
  - Left shift: isr_next = (isr << n) | in_data[n-1:0].
  - n == WIDTH: isr_next = in_data in both directions.
  - cnt_next = min(counter + n, WIDTH).
- Autopush, applied when autopush=1 and cnt_next ≥ thr (thr = push_thresh==0 ? WIDTH : push_thresh):
  - status.full = 0: fifo_data ← isr_next; fifo_push_en ← 1; isr ← 0; counter ← 0.
  - status.full = 1: isr ← isr_next; counter ← cnt_next; state → PUSH_PENDING; stall ← 1.
- Explicit push (IDLE, push_req=1):
  - Not full: fifo_data ← isr; push strobe; isr ← 0; counter ← 0.
  - Full: blocking; stall ← 1, ISR unchanged, the core retries the instruction.
- PUSH_PENDING:
  - shift_en, push_req and mov are ignored; stall stays 1.
  - First cycle with status.full = 0: push isr, clear isr and counter, return to IDLE, stall ← 0.
- MOV:
  - 01: isr ← mov_in; counter ← 0.
  - 10: mov_out ← isr.
  - 11: mov_out ← isr; isr ← 0; counter ← 0.
- Priority within a cycle: reset > PUSH_PENDING > mov > push_req > shift_en. Lower-priority requests in the same cycle are dropped, not queued.
- The counter never wraps; it saturates at WIDTH.
- Shifting further after saturation with autopush off keeps shifting the data, and the counter stays at WIDTH.

Optional Feature:
- Macro: ISR_PUSH_IFFULL_EN.
- Defined: adds input port push_iffull (1 bit). A push_req with push_iffull = 1 is a no-op (no push, no stall) unless counter ≥ thr.
- Undefined: the port is absent and every push_req is unconditional.

Decomposition:
- Package types.svh gains:
  - isr_state_t enum {IDLE, PUSH_PENDING}.
  - isr_mov_t constants MOV_NONE, MOV_WRITE, MOV_READ, MOV_READ_CLR.
  - The existing fifo_status is reused.
- One combinational sub-module, isr_shifter (isr, in_data, n, shiftdir → isr_next). It is shared in style with the OSR shift path.

Test Plan:
- Reset: assert rst low mid-shift → all outputs 0 asynchronously, state IDLE, no push strobe.
- Left shift: isr=0, shift_en, left, in_data=0xA, count=4, twice → isr=0xAA, counter=8.
- Right shift: count=8, in_data=0xFF → isr=0xFF000000, counter=8.
- Autopush: thr=16, two 8-bit shifts of 0x12 then 0x34 (left), fifo not full → next cycle fifo_push_en=1, fifo_data=0x1234, isr=0, counter=0.
- Full stall: same sequence with status.full=1 → stall=1, isr=0x1234 held, counter=16, no strobe. Deassert full → one strobe with 0x1234, then stall=0.
- MOV and count edge cases: MOV write 0xDEADBEEF then MOV read-and-clear → mov_out=0xDEADBEEF, isr=0. shift_count=0 with in_data=0xCAFEF00D → isr=0xCAFEF00D, counter=32.

Source files
------------

// File: rtl/input_shift_register_pkg.sv
// Shared types for the PIO input shift register: FSM states, MOV opcodes, RX fifo status.
package input_shift_register_pkg;

  typedef enum logic {
    StIdle,
    StPushPending
  } isr_state_e;

  typedef enum logic [1:0] {
    MovNone    = 2'b00,
    MovWrite   = 2'b01,
    MovRead    = 2'b10,
    MovReadClr = 2'b11
  } isr_mov_e;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_status_t;

endpackage

// File: rtl/input_shift_register_if.sv
// RX fifo push port: the ISR (master) presents a word and push strobe, the fifo returns status.
interface input_shift_register_if #(
  parameter int unsigned WIDTH = 32
);
  import input_shift_register_pkg::*;

  fifo_status_t     status;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_push_en;

  modport master (input status, output fifo_data, output fifo_push_en);
  modport slave  (output status, input fifo_data, input fifo_push_en);

endinterface

// File: rtl/input_shift_register_shifter.sv
// ISR shift path: merges the n low bits of in_data into isr from either end (n == WIDTH loads in_data).
module input_shift_register_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] isr,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] n,
  input  logic             shiftdir,
  output logic [WIDTH-1:0] isr_next
);

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] src;
  logic [CNT_W-1:0] room;

  // n is 1..WIDTH; shifts by WIDTH yield zero, so n == WIDTH needs no special case.
  always_comb begin
    room     = CNT_W'(WIDTH) - n;
    mask     = {WIDTH{1'b1}} >> room;
    src      = in_data & mask;
    isr_next = shiftdir ? ((isr >> n) | (src << room)) : ((isr << n) | src);
  end

endmodule

// File: rtl/input_shift_register.sv
// PIO input shift register: IN shifts, explicit/auto push to the RX fifo, full stall, MOV access.
// Optional build macro ISR_PUSH_IFFULL_EN adds the push_iffull input.
module input_shift_register
  import input_shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 shift_en,
  input  logic [4:0]           shift_count,
  input  logic                 shiftdir,
  input  logic                 autopush,
  input  logic [4:0]           push_thresh,
  input  logic                 push_req,
`ifdef ISR_PUSH_IFFULL_EN
  input  logic                 push_iffull,
`endif
  input  logic [1:0]           mov,
  input  logic [WIDTH-1:0]     mov_in,
  output logic [WIDTH-1:0]     mov_out,
  input_shift_register_if.master fifo,
  output logic [WIDTH-1:0]     isr,
  output logic [CNT_W-1:0]     input_shift_counter,
  output logic                 stall
);

  isr_state_e       state_q;
  logic [WIDTH-1:0] isr_q, mov_out_q, fifo_data_q, isr_next;
  logic [CNT_W-1:0] cnt_q, n, thr, cnt_next;
  logic [CNT_W:0]   cnt_sum;
  logic             stall_q, push_en_q, push_skip;

  always_comb begin
    n        = (shift_count == 5'd0) ? CNT_W'(WIDTH) : CNT_W'(shift_count);
    thr      = (push_thresh == 5'd0) ? CNT_W'(WIDTH) : CNT_W'(push_thresh);
    cnt_sum  = {1'b0, cnt_q} + {1'b0, n};
    cnt_next = (cnt_sum > (CNT_W + 1)'(WIDTH)) ? CNT_W'(WIDTH) : cnt_sum[CNT_W-1:0];
  end

`ifdef ISR_PUSH_IFFULL_EN
  assign push_skip = push_iffull && (cnt_q < thr);
`else
  assign push_skip = 1'b0;
`endif

  input_shift_register_shifter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shifter (
    .isr      (isr_q),
    .in_data  (in_data),
    .n        (n),
    .shiftdir (shiftdir),
    .isr_next (isr_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      isr_q       <= '0;
      cnt_q       <= '0;
      mov_out_q   <= '0;
      fifo_data_q <= '0;
      push_en_q   <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      push_en_q <= 1'b0;
      unique case (state_q)
        StPushPending: begin
          // Everything else is ignored until the fifo drains.
          if (!fifo.status.full) begin
            fifo_data_q <= isr_q;
            push_en_q   <= 1'b1;
            isr_q       <= '0;
            cnt_q       <= '0;
            stall_q     <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StIdle: begin
          stall_q <= 1'b0;
          if (isr_mov_e'(mov) != MovNone) begin
            unique case (isr_mov_e'(mov))
              MovWrite: begin
                isr_q <= mov_in;
                cnt_q <= '0;
              end
              MovRead: mov_out_q <= isr_q;
              MovReadClr: begin
                mov_out_q <= isr_q;
                isr_q     <= '0;
                cnt_q     <= '0;
              end
              default: ;
            endcase
          end else if (push_req) begin
            if (!push_skip) begin
              if (fifo.status.full) begin
                stall_q <= 1'b1;
              end else begin
                fifo_data_q <= isr_q;
                push_en_q   <= 1'b1;
                isr_q       <= '0;
                cnt_q       <= '0;
              end
            end
          end else if (shift_en) begin
            if (autopush && (cnt_next >= thr)) begin
              if (fifo.status.full) begin
                isr_q   <= isr_next;
                cnt_q   <= cnt_next;
                stall_q <= 1'b1;
                state_q <= StPushPending;
              end else begin
                fifo_data_q <= isr_next;
                push_en_q   <= 1'b1;
                isr_q       <= '0;
                cnt_q       <= '0;
              end
            end else begin
              isr_q <= isr_next;
              cnt_q <= cnt_next;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign isr                 = isr_q;
  assign input_shift_counter = cnt_q;
  assign mov_out             = mov_out_q;
  assign stall               = stall_q;
  assign fifo.fifo_data      = fifo_data_q;
  assign fifo.fifo_push_en   = push_en_q;

endmodule
